// File: rtl/bcd_display_mux_if.sv
// Digit/dp/brightness inputs and segment/anode outputs of the BCD display mux.
interface bcd_display_mux_if;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic [3:0] dp_in;
  logic [3:0] brightness;
  logic [7:0] seg;
  logic [3:0] an;

  modport master (output digit3, digit2, digit1, digit0, dp_in, brightness,
                  input  seg, an);
  modport slave  (input  digit3, digit2, digit1, digit0, dp_in, brightness,
                  output seg, an);
endinterface

// File: rtl/bcd_display_mux.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with frame-tear-free
// shadow capture and 16-level PWM. Optional macro: LEADING_ZERO_BLANK_EN.

module bcd_seg_lane (
  input  logic [3:0] digit,
  output logic [6:0] seg7
);
  always_comb begin
    seg7 = 7'b0111111;  // non-BCD shows '-'
    case (digit)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  end
endmodule

module bcd_display_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             reset,
  bcd_display_mux_if.slave bus
);
  localparam int NUM_DIGITS = 4;
  localparam int RCW = $clog2(REFRESH_DIV);
  localparam logic [RCW-1:0] RLAST = RCW'(REFRESH_DIV - 1);

  logic [RCW-1:0]                 rcnt;
  logic [1:0]                     idx;
  logic                           primed;
  logic [NUM_DIGITS-1:0][3:0]     dig_in;
  logic [NUM_DIGITS-1:0][3:0]     sh_dig;
  logic [NUM_DIGITS-1:0]          sh_dp;
  logic [3:0]                     sh_br;
  logic [NUM_DIGITS-1:0][6:0]     dec;
  logic [NUM_DIGITS-1:0][6:0]     glyph;
  logic                           slot_end;
  logic                           load;
  logic                           lit;
  logic [7:0]                     seg_nxt, seg_q;
  logic [3:0]                     an_nxt, an_q;

  assign dig_in   = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  assign slot_end = (rcnt == RLAST);
  assign load     = !primed || (slot_end && idx == 2'd3);

  // The priming edge only captures the shadow; the scan starts counting after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt   <= '0;
      idx    <= '0;
      primed <= 1'b0;
      sh_dig <= '0;
      sh_dp  <= '0;
      sh_br  <= '0;
    end else begin
      primed <= 1'b1;
      if (load) begin
        sh_dig <= dig_in;
        sh_dp  <= bus.dp_in;
        sh_br  <= bus.brightness;
      end
      if (primed) begin
        rcnt <= slot_end ? '0 : rcnt + 1'b1;
        if (slot_end) idx <= idx + 2'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    bcd_seg_lane u_lane (.digit(sh_dig[g]), .seg7(dec[g]));
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    glyph = dec;
    if (sh_dig[3] == 4'd0) begin
      glyph[3] = 7'h7F;
      if (sh_dig[2] == 4'd0) glyph[2] = 7'h7F;
    end
  end
`else
  assign glyph = dec;
`endif

  always_comb begin
    lit     = primed && (rcnt[3:0] <= sh_br);
    seg_nxt = primed ? {~sh_dp[idx], glyph[idx]} : 8'hFF;
    an_nxt  = lit ? ~(4'b0001 << idx) : 4'b1111;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= 8'hFF;
      an_q  <= 4'b1111;
    end else begin
      seg_q <= seg_nxt;
      an_q  <= an_nxt;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
endmodule
